mem_wait_model: RTL and testbench
=================================

# mem_wait_model

Parametrised, clocked successor of the testbench word memory model: byte-enabled word RAM behind a strobe/ack bus with configurable read and write wait states and an address-range error response. It sits in the basic test bench between the CPU bus master and backing storage, letting tests exercise stall handling that a zero-latency combinational memory cannot provoke.

## Interface
- DATA_WIDTH, 32, word width in bits; multiple of 8
- ADDR_WIDTH, 20, word-address width
- DEPTH, 1 << ADDR_WIDTH, number of implemented words; DEPTH <= 2^ADDR_WIDTH
- RD_LATENCY, 2, cycles from accepting edge to ack edge for reads; >= 1
- WR_LATENCY, 1, same for writes; >= 1
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- address  in  ADDR_WIDTH  word address
- data_i  in  DATA_WIDTH  write data
- byte_enable  in  DATA_WIDTH/8  per-byte lane enable
- rd  in  1  read strobe, single cycle
- wr  in  1  write strobe, single cycle; wins over rd if both high
- data_o  out  DATA_WIDTH  read data, valid while ack high for a read
- busy  out  1  request in flight, strobes ignored
- ack  out  1  one-cycle completion pulse
- err  out  1  qualifies ack: address >= DEPTH
- overrun  out  1  sticky: strobe seen while busy

## Operation
- States IDLE, WAIT. Strobes sampled only in IDLE at a rising edge ("accepting edge"); op = wr ? WRITE : READ; address, data_i, byte_enable latched.
- Latency N = RD_LATENCY or WR_LATENCY per op. N == 1: stay IDLE, complete at accepting edge. N > 1: go WAIT, counter loaded N-2, decrement each edge; at counter 0 complete and return to IDLE.
- Completion edge: ack <= 1 for exactly one cycle; err <= (latched address >= DEPTH).
- Write completion, in range: only enabled lanes of the latched word updated; disabled lanes keep old contents. Out of range: no storage change.
- Read completion, in range: data_o <= stored word with disabled lanes forced to 0. Out of range: data_o <= 0.
- data_o holds last value until next read completion; writes do not change it.
- Strobe at an edge while busy: ignored, overrun <= 1, remains 1 until rst.
- rd and wr together in IDLE: single write, no read, no overrun.

## Timing
- Reset values: busy 0, ack 0, err 0, overrun 0, data_o 0, state IDLE, counter 0. Storage not cleared.
- busy = (state == WAIT); high from accepting edge to completion edge; low in ack cycle.
- ack is registered; asserted in the cycle after completion edge; a request accepted at edge t completes at edge t+N-1, ack high in cycle [t+N-1, t+N).
- Back-to-back: strobe presented in the ack cycle is accepted (state IDLE); throughput one op per N cycles.
- Counter width: clog2 of max(RD_LATENCY, WR_LATENCY), minimum 1.
- rst asserted mid-operation: transaction aborted, pending write never committed, no ack ever issued for it.
- Read-after-write to same address: the read accepted in the write's ack cycle or later returns new data.

## Structure
- Package mem_wait_pkg: state enum {IDLE, WAIT}, op enum {OP_READ, OP_WRITE}, lane-count helper constant.
- One sub-module: mem_byte_array — storage with synchronous byte-enabled write port and asynchronous read, parametrised by DATA_WIDTH and DEPTH. Control FSM, latching, range check and lane masking live in the top.

## Test plan
- Reset, then wr at addr 0x10, data 0xDEADBEEF, be 0xF, WR_LATENCY 1 -> ack next cycle, err 0, busy never high; rd addr 0x10, RD_LATENCY 2 -> busy 1 cycle, then ack with data_o 0xDEADBEEF.
- Partial write be 0x5, data 0x11223344 over 0xDEADBEEF -> read with be 0xF returns 0xDE22BE44; read with be 0x3 returns 0x0000BE44.
- DEPTH 1024, rd at address 1024 -> ack with err 1, data_o 0; wr there -> ack, err 1, address 0 contents unchanged.
- rd strobe during busy -> ignored, overrun 1 and sticky, original read completes with correct data; rd and wr together -> write only.
- RD_LATENCY 4, assert rst two cycles after rd accept -> no ack, busy 0, all outputs at reset values; prior write aborted mid-WAIT is absent on readback.

Source files
------------

// File: rtl/mem_wait_pkg.sv
// mem_wait_pkg: shared types and helpers for the wait-state memory model.
// Exports the FSM state enum, the bus operation enum and a lane-count helper.
package mem_wait_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

    localparam int BYTE_W = 8;

    function automatic int lane_count(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array: word storage with a synchronous byte-enabled write port
// and an asynchronous read port. Contents are never reset.
// Ports:
//   clk      - write clock
//   i_we     - write enable (whole word gated by i_be lanes)
//   i_be     - per-byte lane enable
//   i_addr   - shared read/write word address
//   i_wdata  - write data
//   o_rdata  - combinational read data at i_addr
module mem_byte_array
    import mem_wait_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int AW         = 10
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [AW-1:0]           i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int LANES = lane_count(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (i_we && i_be[i]) begin
                r_mem[i_addr][BYTE_W*i +: BYTE_W] <= i_wdata[BYTE_W*i +: BYTE_W];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_wait_model.sv
// mem_wait_model: byte-enabled word RAM behind a strobe/ack bus with
// configurable read/write wait states and an out-of-range error response.
// Ports:
//   clk, rst             - clock, async active-high reset
//   address, data_i      - word address and write data
//   byte_enable          - per-byte lane enable
//   rd, wr               - single-cycle strobes (wr wins)
//   data_o               - read data, valid with ack on a read
//   busy, ack, err       - in-flight flag, completion pulse, range error
//   overrun              - sticky: strobe seen while busy
module mem_wait_model
    import mem_wait_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 20,
    parameter int DEPTH      = 1 << ADDR_WIDTH,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic [DATA_WIDTH/8-1:0] byte_enable,
    input  logic                    rd,
    input  logic                    wr,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    busy,
    output logic                    ack,
    output logic                    err,
    output logic                    overrun
);

    localparam int LANES  = lane_count(DATA_WIDTH);
    localparam int MAXLAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CW     = ($clog2(MAXLAT) < 1) ? 1 : $clog2(MAXLAT);
    localparam int MAW    = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH);

    localparam logic [CW-1:0] RD_LOAD = CW'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
    localparam logic [CW-1:0] WR_LOAD = CW'((WR_LATENCY > 1) ? WR_LATENCY - 2 : 0);
    localparam bit            RD_ONE  = (RD_LATENCY == 1);
    localparam bit            WR_ONE  = (WR_LATENCY == 1);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  r_state;
    op_t                     r_op;
    logic [CW-1:0]           r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [LANES-1:0]        r_be;
    logic [DATA_WIDTH-1:0]   r_data_o;
    logic                    r_ack;
    logic                    r_err;
    logic                    r_overrun;

    logic                    w_strobe;
    logic                    w_idle;
    op_t                     w_new_op;
    logic                    w_new_one;
    logic                    w_complete;
    op_t                     w_op;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [LANES-1:0]        w_be;
    logic                    w_in_range;
    logic                    w_we;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic [DATA_WIDTH-1:0]   w_rmask;

    assign w_strobe  = rd | wr;
    assign w_idle    = (r_state == IDLE);
    assign w_new_op  = wr ? OP_WRITE : OP_READ;
    assign w_new_one = (w_new_op == OP_WRITE) ? WR_ONE : RD_ONE;

    // Single-cycle ops complete on the accepting edge, so the request is
    // taken straight from the bus; otherwise the latched copy is used.
    assign w_op    = w_idle ? w_new_op    : r_op;
    assign w_addr  = w_idle ? address     : r_addr;
    assign w_wdata = w_idle ? data_i      : r_wdata;
    assign w_be    = w_idle ? byte_enable : r_be;

    assign w_complete = (w_idle && w_strobe && w_new_one) ||
                        (!w_idle && (r_cnt == '0));

    assign w_in_range = ({1'b0, w_addr} < DEPTH_W);
    assign w_we       = w_complete && (w_op == OP_WRITE) && w_in_range;

    always_comb begin
        w_rmask = '0;
        for (int i = 0; i < LANES; i++) begin
            w_rmask[BYTE_W*i +: BYTE_W] = {BYTE_W{w_be[i]}};
        end
    end

    mem_byte_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (MAW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (w_addr[MAW-1:0]),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_op      <= OP_READ;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_data_o  <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_ack <= w_complete;
            r_err <= w_complete && !w_in_range;
            if (w_complete && (w_op == OP_READ)) begin
                r_data_o <= w_in_range ? (w_rdata & w_rmask) : '0;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_strobe) begin
                        r_op    <= w_new_op;
                        r_addr  <= address;
                        r_wdata <= data_i;
                        r_be    <= byte_enable;
                        if (!w_new_one) begin
                            r_state <= WAIT;
                            r_cnt   <= (w_new_op == OP_WRITE) ? WR_LOAD : RD_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (w_strobe) begin
                        r_overrun <= 1'b1;
                    end
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy    = (r_state == WAIT);
    assign ack     = r_ack;
    assign err     = r_err;
    assign overrun = r_overrun;
    assign data_o  = r_data_o;

endmodule

// File: tb/tb_mem_wait_model.sv
// tb_mem_wait_model: directed self-checking bench for mem_wait_model.
// Two instances: A (RD 2 / WR 1, DEPTH 1024) and B (RD 4 / WR 3, DEPTH 16).
module tb_mem_wait_model;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // instance A
    logic        a_rst;
    logic [10:0] a_addr;
    logic [31:0] a_di;
    logic [3:0]  a_be;
    logic        a_rd, a_wr;
    logic [31:0] a_do;
    logic        a_busy, a_ack, a_err, a_ovr;

    // instance B
    logic        b_rst;
    logic [3:0]  b_addr;
    logic [31:0] b_di;
    logic [3:0]  b_be;
    logic        b_rd, b_wr;
    logic [31:0] b_do;
    logic        b_busy, b_ack, b_err, b_ovr;

    int n_chk  = 0;
    int n_pass = 0;

    mem_wait_model #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (11),
        .DEPTH      (1024),
        .RD_LATENCY (2),
        .WR_LATENCY (1)
    ) u_a (
        .clk         (clk),
        .rst         (a_rst),
        .address     (a_addr),
        .data_i      (a_di),
        .byte_enable (a_be),
        .rd          (a_rd),
        .wr          (a_wr),
        .data_o      (a_do),
        .busy        (a_busy),
        .ack         (a_ack),
        .err         (a_err),
        .overrun     (a_ovr)
    );

    mem_wait_model #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (4),
        .DEPTH      (16),
        .RD_LATENCY (4),
        .WR_LATENCY (3)
    ) u_b (
        .clk         (clk),
        .rst         (b_rst),
        .address     (b_addr),
        .data_i      (b_di),
        .byte_enable (b_be),
        .rd          (b_rd),
        .wr          (b_wr),
        .data_o      (b_do),
        .busy        (b_busy),
        .ack         (b_ack),
        .err         (b_err),
        .overrun     (b_ovr)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present a request for one edge on A, then drop the strobes
    task automatic a_req(input logic w, input logic r, input logic [10:0] ad,
                         input logic [31:0] d, input logic [3:0] be);
        a_wr = w; a_rd = r; a_addr = ad; a_di = d; a_be = be;
        tick();
        a_wr = 1'b0; a_rd = 1'b0;
    endtask

    task automatic b_req(input logic w, input logic r, input logic [3:0] ad,
                         input logic [31:0] d, input logic [3:0] be);
        b_wr = w; b_rd = r; b_addr = ad; b_di = d; b_be = be;
        tick();
        b_wr = 1'b0; b_rd = 1'b0;
    endtask

    initial begin
        a_rst = 1'b1; a_addr = '0; a_di = '0; a_be = '0; a_rd = 1'b0; a_wr = 1'b0;
        b_rst = 1'b1; b_addr = '0; b_di = '0; b_be = '0; b_rd = 1'b0; b_wr = 1'b0;
        tick(); tick();
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_ack",  a_ack,  1'b0);
        chk("rst_err",  a_err,  1'b0);
        chk("rst_ovr",  a_ovr,  1'b0);
        chk("rst_do",   a_do,   32'h0);
        a_rst = 1'b0; b_rst = 1'b0;
        tick();

        // full write, WR_LATENCY 1: ack right after the accepting edge
        a_req(1'b1, 1'b0, 11'h010, 32'hDEADBEEF, 4'hF);
        chk("wr_ack",  a_ack,  1'b1);
        chk("wr_err",  a_err,  1'b0);
        chk("wr_busy", a_busy, 1'b0);
        tick();
        chk("wr_ack_pulse", a_ack, 1'b0);

        // read, RD_LATENCY 2: busy for one cycle, then ack with data
        a_req(1'b0, 1'b1, 11'h010, 32'h0, 4'hF);
        chk("rd_busy", a_busy, 1'b1);
        chk("rd_noack", a_ack, 1'b0);
        tick();
        chk("rd_ack",  a_ack,  1'b1);
        chk("rd_busy0", a_busy, 1'b0);
        chk("rd_data", a_do, 32'hDEADBEEF);
        tick();
        chk("rd_ack_pulse", a_ack, 1'b0);

        // partial write, lanes 0 and 2
        a_req(1'b1, 1'b0, 11'h010, 32'h11223344, 4'h5);
        chk("pw_ack", a_ack, 1'b1);
        chk("pw_do_hold", a_do, 32'hDEADBEEF);
        a_req(1'b0, 1'b1, 11'h010, 32'h0, 4'hF);
        tick();
        chk("pw_rd_full", a_do, 32'hDE22BE44);
        a_req(1'b0, 1'b1, 11'h010, 32'h0, 4'h3);
        tick();
        chk("pw_rd_mask", a_do, 32'h0000BE44);

        // out of range at DEPTH boundary
        a_req(1'b1, 1'b0, 11'h000, 32'hCAFEF00D, 4'hF);
        a_req(1'b1, 1'b0, 11'h3FF, 32'h0BADCAFE, 4'hF);
        chk("last_ok_err", a_err, 1'b0);
        a_req(1'b0, 1'b1, 11'h400, 32'h0, 4'hF);
        tick();
        chk("oor_rd_ack", a_ack, 1'b1);
        chk("oor_rd_err", a_err, 1'b1);
        chk("oor_rd_do",  a_do,  32'h0);
        tick();
        chk("oor_err_pulse", a_err, 1'b0);
        a_req(1'b1, 1'b0, 11'h400, 32'h12345678, 4'hF);
        chk("oor_wr_ack", a_ack, 1'b1);
        chk("oor_wr_err", a_err, 1'b1);
        a_req(1'b0, 1'b1, 11'h000, 32'h0, 4'hF);
        tick();
        chk("oor_addr0", a_do, 32'hCAFEF00D);
        chk("addr0_err", a_err, 1'b0);
        a_req(1'b0, 1'b1, 11'h3FF, 32'h0, 4'hF);
        tick();
        chk("last_word", a_do, 32'h0BADCAFE);

        // strobe while busy is ignored but flagged
        a_req(1'b0, 1'b1, 11'h010, 32'h0, 4'hF);
        chk("ovr_pre", a_ovr, 1'b0);
        a_req(1'b0, 1'b1, 11'h000, 32'h0, 4'hF);
        chk("ovr_set", a_ovr, 1'b1);
        chk("ovr_ack", a_ack, 1'b1);
        chk("ovr_data", a_do, 32'hDE22BE44);
        tick();
        chk("ovr_ignored_ack", a_ack, 1'b0);
        chk("ovr_ignored_busy", a_busy, 1'b0);

        // rd+wr together: a single write, no stall, data_o untouched
        a_req(1'b1, 1'b1, 11'h030, 32'h55AA55AA, 4'hF);
        chk("rw_busy", a_busy, 1'b0);
        chk("rw_ack",  a_ack,  1'b1);
        chk("rw_do",   a_do,   32'hDE22BE44);
        chk("ovr_sticky", a_ovr, 1'b1);
        // read presented in the write's ack cycle sees new data
        a_req(1'b0, 1'b1, 11'h030, 32'h0, 4'hF);
        chk("raw_busy", a_busy, 1'b1);
        tick();
        chk("raw_data", a_do, 32'h55AA55AA);
        // back-to-back read accepted in the previous read's ack cycle
        a_req(1'b0, 1'b1, 11'h010, 32'h0, 4'hF);
        chk("b2b_busy", a_busy, 1'b1);
        tick();
        chk("b2b_ack",  a_ack, 1'b1);
        chk("b2b_data", a_do, 32'hDE22BE44);
        chk("ovr_sticky2", a_ovr, 1'b1);

        // instance B: WR 3, RD 4
        b_req(1'b1, 1'b0, 4'h3, 32'h12345678, 4'hF);
        chk("b_wr_busy", b_busy, 1'b1);
        tick();
        chk("b_wr_noack", b_ack, 1'b0);
        tick();
        chk("b_wr_ack", b_ack, 1'b1);
        chk("b_wr_busy0", b_busy, 1'b0);
        b_req(1'b0, 1'b1, 4'h3, 32'h0, 4'hF);
        tick(); tick();
        chk("b_rd_noack", b_ack, 1'b0);
        tick();
        chk("b_rd_ack", b_ack, 1'b1);
        chk("b_rd_data", b_do, 32'h12345678);

        // write aborted by reset mid-wait
        tick();
        b_req(1'b1, 1'b0, 4'h3, 32'hAAAAAAAA, 4'hF);
        tick();
        b_rst = 1'b1;
        #1;
        chk("b_abw_busy", b_busy, 1'b0);
        tick();
        b_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b_abw_noack", b_ack, 1'b0);
        end

        // read aborted by reset two cycles after accept
        b_req(1'b0, 1'b1, 4'h3, 32'h0, 4'hF);
        tick(); tick();
        b_rst = 1'b1;
        #1;
        chk("b_abr_busy", b_busy, 1'b0);
        chk("b_abr_ack",  b_ack,  1'b0);
        chk("b_abr_err",  b_err,  1'b0);
        chk("b_abr_ovr",  b_ovr,  1'b0);
        chk("b_abr_do",   b_do,   32'h0);
        tick();
        b_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b_abr_noack", b_ack, 1'b0);
        end

        // aborted write never reached storage
        b_req(1'b0, 1'b1, 4'h3, 32'h0, 4'hF);
        tick(); tick(); tick();
        chk("b_post_ack",  b_ack, 1'b1);
        chk("b_post_data", b_do,  32'h12345678);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
